// File: rtl/mgmt_storage_wb_pkg.sv
// Shared constants and types for the management storage Wishbone slave.
// Status codes are the values firmware writes to report test progress on checkbits.
package mgmt_storage_wb_pkg;

  localparam int WB_DW      = 32;
  localparam int STATUS_OFF = 0;

  typedef enum logic [15:0] {
    TEST_START = 16'hA040,
    TEST_FAIL  = 16'hAB40,
    TEST_PASS  = 16'hAB41
  } status_code_e;

  // Which source feeds the read-data port after an accepted read.
  typedef enum logic {
    SRC_REG  = 1'b0,
    SRC_BANK = 1'b1
  } rd_src_e;

  // Expands the 4 byte-lane enables into a 32-bit bit mask.
  function automatic logic [WB_DW-1:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/mgmt_storage_wb_if.sv
// Wishbone classic slave-side bundle between the management core and the storage block.
interface mgmt_storage_wb_if;
  import mgmt_storage_wb_pkg::*;

  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic             wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [31:0]      wbs_adr_i;
  logic [WB_DW-1:0] wbs_dat_i;
  logic [WB_DW-1:0] wbs_dat_o;
  logic             wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );

endinterface

// File: rtl/mgmt_storage_wb_storage_bank_bw.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
// Each byte lane is its own array so the tools map it onto a block RAM lane.
module storage_bank_bw #(
  parameter int ADDR_W    = 8,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              en,
  input  logic              wr,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_reg;

    always_ff @(posedge clk) begin
      if (en && wr && be[gi]) begin
        mem[addr] <= wdata[8*gi +: 8];
      end
    end

    // Only the output register is cleared; stored contents never see reset.
    always_ff @(posedge clk) begin
      if (srst && INIT_ZERO) begin
        rd_reg <= '0;
      end else if (en && !wr) begin
        rd_reg <= mem[addr];
      end
    end

    assign rdata[8*gi +: 8] = rd_reg;
  end

endmodule

// File: rtl/mgmt_storage_wb.sv
// Wishbone classic slave: storage bank below bit ADDR_W+2, register space above it.
// The status register is mirrored onto checkbits so test progress is visible off-chip.
module mgmt_storage_wb
  import mgmt_storage_wb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  mgmt_storage_wb_if.slave wb,
  output logic [15:0]  checkbits
);

  logic              accept;
  logic              is_reg;
  logic              is_status;
  logic [ADDR_W-1:0] word_idx;
  logic              bank_en;
  logic [WB_DW-1:0]  bank_rd;
  logic [WB_DW-1:0]  sel_mask;

  logic              ack_reg;
  logic [15:0]       status_reg;
  rd_src_e           rd_src_reg;
  logic [WB_DW-1:0]  reg_rd_reg;

  // Holding off acceptance while ack is high gives the 2-cycle cadence.
  assign accept    = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_reg;
  assign is_reg    = wb.wbs_adr_i[ADDR_W+2];
  assign word_idx  = wb.wbs_adr_i[ADDR_W+1:2];
  assign is_status = is_reg & (word_idx == ADDR_W'(STATUS_OFF));
  assign bank_en   = accept & ~is_reg & ~wb_rst_i;
  assign sel_mask  = lane_mask(wb.wbs_sel_i);

  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb.wbs_adr_i[31:ADDR_W+3], wb.wbs_adr_i[1:0], sel_mask[31:16]};

  storage_bank_bw #(
    .ADDR_W    (ADDR_W),
    .INIT_ZERO (INIT_ZERO)
  ) u_bank (
    .clk   (wb_clk_i),
    .srst  (wb_rst_i),
    .en    (bank_en),
    .wr    (wb.wbs_we_i),
    .be    (wb.wbs_sel_i),
    .addr  (word_idx),
    .wdata (wb.wbs_dat_i),
    .rdata (bank_rd)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg    <= 1'b0;
      status_reg <= '0;
      rd_src_reg <= SRC_REG;
      reg_rd_reg <= '0;
    end else begin
      ack_reg <= accept;
      if (accept && wb.wbs_we_i && is_status) begin
        status_reg <= (status_reg & ~sel_mask[15:0]) | (wb.wbs_dat_i[15:0] & sel_mask[15:0]);
      end
      if (accept && !wb.wbs_we_i) begin
        rd_src_reg <= is_reg ? SRC_REG : SRC_BANK;
        reg_rd_reg <= is_status ? {16'h0000, status_reg} : '0;
      end
    end
  end

  assign wb.wbs_ack_o = ack_reg;
  assign wb.wbs_dat_o = (rd_src_reg == SRC_BANK) ? bank_rd : reg_rd_reg;
  assign checkbits    = status_reg;

endmodule

// File: tb/tb_mgmt_storage_wb.sv
// Directed bench for mgmt_storage_wb: read expectations are queued at issue and popped on ack.
module tb_mgmt_storage_wb;
  import mgmt_storage_wb_pkg::*;

  localparam logic [31:0] REG_BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] checkbits;
  int          passes = 0;
  int          total  = 0;
  logic [31:0] exp_q [$];

  mgmt_storage_wb_if bus ();

  mgmt_storage_wb #(
    .ADDR_W    (8),
    .INIT_ZERO (1'b0)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb        (bus),
    .checkbits (checkbits)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
  endtask

  task automatic access(input bit w, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [31:0] exp, input string tag);
    int n = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = w;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    if (!w) exp_q.push_back(exp);
    do begin
      tick();
      n++;
    end while (bus.wbs_ack_o !== 1'b1 && n < 8);
    check({tag, " ack_latency"}, n, 1);
    if (!w && exp_q.size() > 0) begin
      check({tag, " rdata"}, bus.wbs_dat_o, exp_q.pop_front());
    end
    $display("txn %-14s we=%0d adr=%h sel=%b wdat=%h rdat=%h ack_cycles=%0d",
             tag, w, adr, sel, dat, bus.wbs_dat_o, n);
    idle();
    tick();
    check({tag, " ack_drop"}, {31'b0, bus.wbs_ack_o}, 32'h0);
  endtask

  initial begin
    int acks;
    idle();

    // Power-on reset
    rst = 1'b1;
    repeat (2) tick();
    check("rst ack", {31'b0, bus.wbs_ack_o}, 32'h0);
    check("rst dat_o", bus.wbs_dat_o, 32'h0);
    check("rst checkbits", {16'h0, checkbits}, 32'h0);
    rst = 1'b0;
    tick();

    // Word read/write, including top word and ignored high address bits
    access(1, 32'h0000_0000, 4'hF, 32'hDEADBEEF, '0, "wr w0");
    access(1, 32'h0000_03FC, 4'hF, 32'hCAFEF00D, '0, "wr w255");
    access(0, 32'h0000_0000, 4'hF, '0, 32'hDEADBEEF, "rd w0");
    access(0, 32'h0000_03FC, 4'hF, '0, 32'hCAFEF00D, "rd w255");
    access(0, 32'h0000_0800, 4'hF, '0, 32'hDEADBEEF, "rd alias w0");

    // Byte lanes
    access(1, 32'h0000_000C, 4'hF, 32'hFFFFFFFF, '0, "wr w3 ones");
    access(1, 32'h0000_000C, 4'b0101, 32'h00000000, '0, "wr w3 sel0101");
    access(0, 32'h0000_000C, 4'hF, '0, 32'hFF00FF00, "rd w3");
    access(1, 32'h0000_000C, 4'b0000, 32'h12345678, '0, "wr w3 sel0000");
    access(0, 32'h0000_000C, 4'hF, '0, 32'hFF00FF00, "rd w3 again");

    // Status register
    access(1, REG_BASE, 4'b0011, {16'h0, TEST_START}, '0, "wr status");
    check("checkbits start", {16'h0, checkbits}, {16'h0, TEST_START});
    access(1, REG_BASE, 4'hF, 32'hFFFFAB41, '0, "wr status hi");
    check("checkbits pass", {16'h0, checkbits}, {16'h0, TEST_PASS});
    access(0, REG_BASE, 4'hF, '0, 32'h0000AB41, "rd status");
    access(1, REG_BASE, 4'b1100, 32'h00000000, '0, "wr status sel");
    check("checkbits sel", {16'h0, checkbits}, {16'h0, TEST_PASS});
    access(0, REG_BASE + 32'h4, 4'hF, '0, 32'h0, "rd reg off1");

    // stb held for 6 cycles: ack pattern 1,0,1,0,1,0
    acks = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h0000_0000;
    repeat (3) exp_q.push_back(32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("burst ack c%0d", i), {31'b0, bus.wbs_ack_o}, {31'b0, ((i % 2) == 0)});
      if (bus.wbs_ack_o === 1'b1) begin
        acks++;
        if (exp_q.size() > 0) check($sformatf("burst rdata c%0d", i), bus.wbs_dat_o, exp_q.pop_front());
      end
    end
    $display("txn burst          acks=%0d", acks);
    check("burst ack count", acks, 3);
    exp_q.delete();
    idle();
    tick();

    // stb without cyc
    acks = 0;
    bus.wbs_stb_i = 1'b1;
    repeat (4) begin
      tick();
      if (bus.wbs_ack_o === 1'b1) acks++;
    end
    $display("txn stb_no_cyc     acks=%0d", acks);
    check("stb no cyc acks", acks, 0);
    idle();
    tick();

    // Contents survive reset; outputs clear
    access(1, 32'h0000_0014, 4'hF, 32'h12345678, '0, "wr w5");
    access(0, 32'h0000_0014, 4'hF, '0, 32'h12345678, "rd w5");
    rst = 1'b1;
    repeat (2) tick();
    check("rst2 ack", {31'b0, bus.wbs_ack_o}, 32'h0);
    check("rst2 dat_o", bus.wbs_dat_o, 32'h0);
    check("rst2 checkbits", {16'h0, checkbits}, 32'h0);
    rst = 1'b0;
    tick();
    access(0, 32'h0000_0014, 4'hF, '0, 32'h12345678, "rd w5 post rst");

    // Reset on the accepting edge of a write cancels it
    access(1, 32'h0000_001C, 4'hF, 32'h11111111, '0, "wr w7 old");
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h0000_001C;
    bus.wbs_dat_i = 32'h55AA55AA;
    rst = 1'b1;
    tick();
    check("midrst ack", {31'b0, bus.wbs_ack_o}, 32'h0);
    $display("txn midrst write   ack=%0d", bus.wbs_ack_o);
    rst = 1'b0;
    idle();
    tick();
    check("midrst ack after", {31'b0, bus.wbs_ack_o}, 32'h0);
    access(0, 32'h0000_001C, 4'hF, '0, 32'h11111111, "rd w7");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
